// File: rtl/profile_gen_pkg.sv
// -----------------------------------------------------------------------------
// profile_gen_pkg
// Shared definitions for the cascaded-integrator motion profile generator:
// default chain depth, parameter-address field layout and the sweep state
// encoding used by profile_generator.
// -----------------------------------------------------------------------------
package profile_gen_pkg;

    localparam int N_STAGES_DEFAULT = 9;

    // param_addr layout: [INDEX_MSB:0] entry index, [7:BANK_LSB] bank
    localparam int INDEX_MSB = 4;
    localparam int BANK_LSB  = 5;
    localparam int IDX_W     = INDEX_MSB + 1;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        ADD_LO,
        ADD_HI
    } sweep_state_t;

endpackage

// File: rtl/pg_word_ram.sv
// -----------------------------------------------------------------------------
// pg_word_ram
// 32-bit x DEPTH register array with one synchronous write port and two
// combinational read ports. Reads of addresses at or beyond DEPTH return 0,
// writes to such addresses are dropped.
//
// Ports:
//   clk        in   clock
//   i_we       in   write enable
//   i_waddr    in   write address
//   i_wdata    in   write data
//   i_raddr_a  in   read port A address
//   o_rdata_a  out  read port A data
//   i_raddr_b  in   read port B address
//   o_rdata_b  out  read port B data
// -----------------------------------------------------------------------------
module pg_word_ram
    import profile_gen_pkg::*;
#(
    parameter int DEPTH = N_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic [IDX_W-1:0] i_raddr_a,
    output logic [31:0]      o_rdata_a,
    input  logic [IDX_W-1:0] i_raddr_b,
    output logic [31:0]      o_rdata_b
);

    localparam int               AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we && (i_waddr <= LAST)) begin
            r_mem[i_waddr[AW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a <= LAST) ? r_mem[i_raddr_a[AW-1:0]] : '0;
    assign o_rdata_b = (i_raddr_b <= LAST) ? r_mem[i_raddr_b[AW-1:0]] : '0;

endmodule

// File: rtl/profile_generator.sv
// -----------------------------------------------------------------------------
// profile_generator
// Cascaded-integrator motion profile generator. N_STAGES signed 64-bit
// entries s[0..N_STAGES-1] are stored as low/high 32-bit words in two
// pg_word_ram instances. Each accepted acc_step runs a sweep
// s[i] <= s[i] + s[i+1] for i = 0 .. N_STAGES-2, two cycles per stage
// (low half with carry-out, then high half with carry-in). s[0] is published
// on pos when the sweep finishes.
//
// Optional build macro: PROFILE_GEN_OVERRUN_EN adds the sticky overrun flag.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   acc_step        in   advance the profile one step (ignored while busy)
//   param_addr      in   [4:0] entry index, [7:5] bank (only bank 0 valid)
//   param_in        in   32-bit write data
//   param_write_lo  in   write bits 31:0 of the addressed entry
//   param_write_hi  in   write bits 63:32 (both set: sign-extended full write)
//   param_out       out  registered readback of the addressed entry
//   pos             out  s[0], updated when a sweep completes
//   busy            out  high during the clear sweep and step sweeps
//   overrun         out  (PROFILE_GEN_OVERRUN_EN only) acc_step seen while busy
// -----------------------------------------------------------------------------
module profile_generator
    import profile_gen_pkg::*;
#(
    parameter int N_STAGES = N_STAGES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        acc_step,
    input  logic [7:0]  param_addr,
    input  logic [31:0] param_in,
    input  logic        param_write_lo,
    input  logic        param_write_hi,
    output logic [63:0] param_out,
    output logic [63:0] pos,
    output logic        busy
`ifdef PROFILE_GEN_OVERRUN_EN
    ,
    output logic        overrun
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);
    localparam logic [IDX_W-1:0] LAST_ADD = IDX_W'(N_STAGES - 2);

    sweep_state_t     r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [63:0]      r_pos_next;

    logic [IDX_W-1:0] w_index;
    logic [2:0]       w_bank;
    logic             w_addr_ok;
    logic             w_idle;
    logic             w_sweeping;
    logic             w_wr_acc;

    logic [IDX_W-1:0] w_raddr_a;
    logic [IDX_W-1:0] w_raddr_b;
    logic [31:0]      w_lo_a, w_lo_b, w_hi_a, w_hi_b;
    logic [32:0]      w_lo_sum;
    logic [31:0]      w_hi_sum;

    logic             w_we_lo, w_we_hi;
    logic [IDX_W-1:0] w_waddr;
    logic [31:0]      w_wdata_lo, w_wdata_hi;

    assign w_index    = param_addr[INDEX_MSB:0];
    assign w_bank     = param_addr[7:BANK_LSB];
    assign w_addr_ok  = (w_bank == 3'd0) && (w_index <= LAST_IDX);
    assign w_idle     = (r_state == IDLE);
    assign w_sweeping = (r_state == ADD_LO) || (r_state == ADD_HI);
    assign w_wr_acc   = w_idle && w_addr_ok && (param_write_lo || param_write_hi);

    // Port A serves host readback when idle and s[i] during a sweep;
    // port B always presents s[i+1], which is still its pre-step value
    // because the sweep walks upward from index 0.
    assign w_raddr_a = w_sweeping ? r_idx : w_index;
    assign w_raddr_b = r_idx + IDX_W'(1);

    assign w_lo_sum = {1'b0, w_lo_a} + {1'b0, w_lo_b};
    assign w_hi_sum = w_hi_a + w_hi_b + {31'd0, r_carry};

    always_comb begin
        w_we_lo    = 1'b0;
        w_we_hi    = 1'b0;
        w_waddr    = r_idx;
        w_wdata_lo = '0;
        w_wdata_hi = '0;
        case (r_state)
            CLEAR: begin
                w_we_lo = 1'b1;
                w_we_hi = 1'b1;
            end
            IDLE: begin
                w_waddr    = w_index;
                w_we_lo    = w_addr_ok && param_write_lo;
                w_we_hi    = w_addr_ok && param_write_hi;
                w_wdata_lo = param_in;
                // lo+hi together loads a sign-extended 32-bit value
                w_wdata_hi = param_write_lo ? {32{param_in[31]}} : param_in;
            end
            ADD_LO: begin
                w_we_lo    = 1'b1;
                w_wdata_lo = w_lo_sum[31:0];
            end
            ADD_HI: begin
                w_we_hi    = 1'b1;
                w_wdata_hi = w_hi_sum;
            end
            default: ;
        endcase
    end

    pg_word_ram #(.DEPTH(N_STAGES)) u_mem0 (
        .clk      (clk),
        .i_we     (w_we_lo),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata_lo),
        .i_raddr_a(w_raddr_a),
        .o_rdata_a(w_lo_a),
        .i_raddr_b(w_raddr_b),
        .o_rdata_b(w_lo_b)
    );

    pg_word_ram #(.DEPTH(N_STAGES)) u_mem1 (
        .clk      (clk),
        .i_we     (w_we_hi),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata_hi),
        .i_raddr_a(w_raddr_a),
        .o_rdata_a(w_hi_a),
        .i_raddr_b(w_raddr_b),
        .o_rdata_b(w_hi_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_idx     <= '0;
            busy      <= 1'b1;
            pos       <= '0;
            param_out <= '0;
        end else begin
            param_out <= w_addr_ok ? {w_hi_a, w_lo_a} : 64'd0;
            case (r_state)
                CLEAR: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                        busy    <= 1'b0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                IDLE: begin
                    if (acc_step) begin
                        r_state <= ADD_LO;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                    end
                end
                ADD_LO: begin
                    r_carry <= w_lo_sum[32];
                    r_state <= ADD_HI;
                    if (r_idx == '0) begin
                        r_pos_next[31:0] <= w_lo_sum[31:0];
                    end
                end
                ADD_HI: begin
                    if (r_idx == '0) begin
                        r_pos_next[63:32] <= w_hi_sum;
                    end
                    if (r_idx == LAST_ADD) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        // With a two-entry chain stage 0 is also the last
                        // stage, so its high half is not yet in r_pos_next.
                        pos     <= (r_idx == '0) ? {w_hi_sum, r_pos_next[31:0]}
                                                 : r_pos_next;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= ADD_LO;
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

`ifdef PROFILE_GEN_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (acc_step && busy) begin
            overrun <= 1'b1;
        end else if (w_wr_acc) begin
            overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_profile_generator.sv
// -----------------------------------------------------------------------------
// tb_profile_generator
// Directed self-checking bench for profile_generator (N_STAGES = 9).
// Honours PROFILE_GEN_OVERRUN_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_profile_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_step;
    logic [7:0]  param_addr;
    logic [31:0] param_in;
    logic        param_write_lo;
    logic        param_write_hi;
    logic [63:0] param_out;
    logic [63:0] pos;
    logic        busy;
`ifdef PROFILE_GEN_OVERRUN_EN
    logic        overrun;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    profile_generator dut (
        .clk           (clk),
        .rst           (rst),
        .acc_step      (acc_step),
        .param_addr    (param_addr),
        .param_in      (param_in),
        .param_write_lo(param_write_lo),
        .param_write_hi(param_write_hi),
        .param_out     (param_out),
        .pos           (pos),
        .busy          (busy)
`ifdef PROFILE_GEN_OVERRUN_EN
        ,
        .overrun       (overrun)
`endif
    );

    logic [63:0] exp_init [9] = '{64'd1, 64'd0, 64'd0, 64'd3, 64'd4, 64'd5, 64'd0, 64'd0, 64'd0};
    logic [63:0] exp_s1   [6] = '{64'd1, 64'd0, 64'd3, 64'd7, 64'd9, 64'd5};
    logic [63:0] exp_s2   [6] = '{64'd1, 64'd3, 64'd10, 64'd16, 64'd14, 64'd5};
    logic [63:0] exp_s3   [6] = '{64'd4, 64'd13, 64'd26, 64'd30, 64'd19, 64'd5};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data,
                      input logic lo, input logic hi);
        param_addr     = addr;
        param_in       = data;
        param_write_lo = lo;
        param_write_hi = hi;
        tick();
        param_write_lo = 1'b0;
        param_write_hi = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr, input logic [63:0] exp, input string tag);
        param_addr = addr;
        tick();
        check(tag, param_out, exp);
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    task automatic step(input string tag);
        int cnt;
        acc_step = 1'b1;
        tick();
        acc_step = 1'b0;
        wait_idle(cnt);
        check(tag, 64'(cnt), 64'd16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst            = 1'b1;
        acc_step       = 1'b0;
        param_addr     = '0;
        param_in       = '0;
        param_write_lo = 1'b0;
        param_write_hi = 1'b0;

        tick(); tick(); tick();
        check("rst_busy", {63'd0, busy}, 64'd1);
        check("rst_pos", pos, 64'd0);
        check("rst_param_out", param_out, 64'd0);

        rst = 1'b0;
        wait_idle(cnt);
        check("clear_cycles", 64'(cnt), 64'd9);
        for (int i = 0; i < 9; i++) rd(8'(i), 64'd0, $sformatf("clear_s%0d", i));
        check("clear_pos", pos, 64'd0);

        for (int i = 0; i < 8; i++) wr(8'(i), 32'd0, 1'b1, 1'b1);
        wr(8'h00, 32'd1, 1'b1, 1'b0);
        wr(8'h03, 32'd3, 1'b1, 1'b0);
        wr(8'h04, 32'd4, 1'b1, 1'b0);
        wr(8'h05, 32'd5, 1'b1, 1'b0);
        for (int b = 1; b < 8; b++) wr(8'(b << 5), 32'hDEADBEEF, 1'b1, 1'b1);
        wr(8'h09, 32'hDEADBEEF, 1'b1, 1'b1);
        wr(8'h1F, 32'hDEADBEEF, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) rd(8'(i), exp_init[i], $sformatf("init_s%0d", i));
        rd(8'h20, 64'd0, "bank_read_0x20");
        rd(8'h09, 64'd0, "oob_read_0x09");

        step("busy_len_step1");
        for (int i = 0; i < 6; i++) rd(8'(i), exp_s1[i], $sformatf("step1_s%0d", i));
        repeat (80) tick();
        step("busy_len_step2");
        for (int i = 0; i < 6; i++) rd(8'(i), exp_s2[i], $sformatf("step2_s%0d", i));
        repeat (80) tick();
        step("busy_len_step3");
        for (int i = 0; i < 6; i++) rd(8'(i), exp_s3[i], $sformatf("step3_s%0d", i));
        check("step3_pos", pos, 64'd4);

        wr(8'h00, 32'hFFFFFFFF, 1'b1, 1'b0);
        wr(8'h00, 32'h00000000, 1'b0, 1'b1);
        wr(8'h01, 32'd1, 1'b1, 1'b1);
        step("busy_len_carry");
        rd(8'h00, 64'h00000001_00000000, "carry_s0");
        check("carry_pos", pos, 64'h00000001_00000000);

        wr(8'h00, 32'hFFFFFFFF, 1'b1, 1'b1);
        wr(8'h01, 32'd1, 1'b1, 1'b1);
        step("busy_len_wrap");
        rd(8'h00, 64'd0, "wrap_s0");
        check("wrap_pos", pos, 64'd0);

        wr(8'h02, 32'd5, 1'b1, 1'b1);
        wr(8'h02, 32'h12345678, 1'b0, 1'b1);
        rd(8'h02, 64'h12345678_00000005, "hi_only");
        wr(8'h02, 32'h80000000, 1'b1, 1'b1);
        rd(8'h02, 64'hFFFFFFFF_80000000, "lohi_sext");

        for (int i = 0; i < 9; i++) wr(8'(i), 32'd0, 1'b1, 1'b1);
        wr(8'h00, 32'd10, 1'b1, 1'b1);
        wr(8'h01, 32'd2, 1'b1, 1'b1);
        acc_step = 1'b1;
        tick();
        acc_step = 1'b0;
        check("busy_rise", {63'd0, busy}, 64'd1);
        tick(); tick(); tick();
        acc_step = 1'b1;
        wr(8'h01, 32'd100, 1'b1, 1'b1);
        acc_step = 1'b0;
        wait_idle(cnt);
        repeat (5) tick();
        check("no_second_sweep", {63'd0, busy}, 64'd0);
        rd(8'h00, 64'd12, "busy_ignore_s0");
        rd(8'h01, 64'd2, "busy_ignore_s1");
        check("busy_ignore_pos", pos, 64'd12);
`ifdef PROFILE_GEN_OVERRUN_EN
        check("overrun_set", {63'd0, overrun}, 64'd1);
        wr(8'h03, 32'd0, 1'b1, 1'b1);
        check("overrun_clear", {63'd0, overrun}, 64'd0);
`endif

        param_addr     = 8'h01;
        param_in       = 32'd7;
        param_write_lo = 1'b1;
        param_write_hi = 1'b1;
        acc_step       = 1'b1;
        tick();
        param_write_lo = 1'b0;
        param_write_hi = 1'b0;
        acc_step       = 1'b0;
        wait_idle(cnt);
        check("wr_step_busy_len", 64'(cnt), 64'd16);
        rd(8'h00, 64'd19, "wr_step_s0");
        check("wr_step_pos", pos, 64'd19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
